// File: rtl/forwarding_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_pkg
//  Description : Shared widths, per-port state encoding and the lookup
//                result record for the decode-stage forwarding unit.
//  Revision    : 1.0  initial release
// ============================================================================
package forwarding_pkg;

    localparam int c_NUM_PORTS         = 2;
    localparam int c_NUM_STAGES        = 3;
    localparam int c_DATA_WIDTH        = 32;
    localparam int c_REG_ID_WIDTH      = 5;
    localparam int c_STALL_COUNT_WIDTH = 16;

    // Per-port operand capture state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no instruction owns this port
        WAIT = 2'd1,   // producer found but its result is not ready yet
        HELD = 2'd2    // operand captured and frozen until the next issue
    } portState_t;

    // Outcome of one port's producer search at the default operand width.
    typedef struct packed {
        logic                    hit;
        logic                    ready;
        logic [c_DATA_WIDTH-1:0] data;
    } lookupResult_t;

endpackage : forwarding_pkg
`default_nettype wire

// File: rtl/forwarding_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_lookup
//  Description : Combinational priority search of the producer stages for a
//                single read port. The youngest matching stage wins, even if
//                its result is not ready, so an older ready copy can never
//                leak through ahead of a newer write. o_data is the value to
//                capture once the search resolves.
//  Revision    : 1.0  initial release
// ============================================================================
module forwarding_lookup
    import forwarding_pkg::*;
#(
    parameter int NUM_STAGES   = c_NUM_STAGES,
    parameter int DATA_WIDTH   = c_DATA_WIDTH,
    parameter int REG_ID_WIDTH = c_REG_ID_WIDTH
) (
    input  logic [REG_ID_WIDTH-1:0]            i_readRegId,
    input  logic [DATA_WIDTH-1:0]              i_readData,
    input  logic [NUM_STAGES*REG_ID_WIDTH-1:0] i_stageRegId,
    input  logic [NUM_STAGES-1:0]              i_stageDataReady,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0]   i_stageData,
    output logic                               o_hit,
    output logic                               o_ready,
    output logic [DATA_WIDTH-1:0]              o_data
);

    // Walk from the oldest stage to the youngest so the last match written
    // is the youngest one; register 0 never matches a producer.
    always_comb begin
        o_hit   = 1'b0;
        o_ready = 1'b0;
        o_data  = i_readData;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if ((i_readRegId != '0) &&
                (i_stageRegId[i*REG_ID_WIDTH +: REG_ID_WIDTH] == i_readRegId)) begin
                o_hit   = 1'b1;
                o_ready = i_stageDataReady[i];
                o_data  = i_stageData[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule : forwarding_lookup
`default_nettype wire

// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_hazard_unit
//  Description : Decode-stage operand forwarding and stall control for
//                NUM_PORTS read ports. Each port runs its own IDLE/WAIT/HELD
//                machine, captures its operand once and holds it; stall is
//                the registered OR of ports heading into WAIT. A saturating
//                counter tallies stalled cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module forwarding_hazard_unit
    import forwarding_pkg::*;
#(
    parameter int NUM_PORTS         = c_NUM_PORTS,
    parameter int NUM_STAGES        = c_NUM_STAGES,
    parameter int DATA_WIDTH        = c_DATA_WIDTH,
    parameter int REG_ID_WIDTH      = c_REG_ID_WIDTH,
    parameter int STALL_COUNT_WIDTH = c_STALL_COUNT_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               issueValid,
    input  logic                               flush,
    input  logic [NUM_PORTS*REG_ID_WIDTH-1:0]  readRegId,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    readData,
    input  logic [NUM_STAGES*REG_ID_WIDTH-1:0] stageRegId,
    input  logic [NUM_STAGES-1:0]              stageDataReady,
    input  logic [NUM_STAGES*DATA_WIDTH-1:0]   stageData,
    input  logic                               counterClear,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    forwardedData,
    output logic                               stall,
    output logic [STALL_COUNT_WIDTH-1:0]       stallCycles
);

    logic [NUM_PORTS-1:0]         w_portWait;
    logic                         w_issueAccepted;
    logic                         r_stall;
    logic [STALL_COUNT_WIDTH-1:0] r_stallCycles;

    // An issue arriving while stalled is ignored; flush overrides issue.
    assign w_issueAccepted = issueValid && !r_stall && !flush;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            logic                  w_hit;
            logic                  w_ready;
            logic                  w_pending;
            logic                  w_latch;
            logic [DATA_WIDTH-1:0] w_data;
            logic [DATA_WIDTH-1:0] r_data;
            portState_t            r_state;
            portState_t            w_nextState;

            forwarding_lookup #(
                .NUM_STAGES   (NUM_STAGES),
                .DATA_WIDTH   (DATA_WIDTH),
                .REG_ID_WIDTH (REG_ID_WIDTH)
            ) u_lookup (
                .i_readRegId      (readRegId[p*REG_ID_WIDTH +: REG_ID_WIDTH]),
                .i_readData       (readData[p*DATA_WIDTH +: DATA_WIDTH]),
                .i_stageRegId     (stageRegId),
                .i_stageDataReady (stageDataReady),
                .i_stageData      (stageData),
                .o_hit            (w_hit),
                .o_ready          (w_ready),
                .o_data           (w_data)
            );

            assign w_pending = w_hit && !w_ready;

            // Port state register.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) r_state <= IDLE;
                else        r_state <= w_nextState;
            end

            // Next state: new issues resolve or wait; WAIT re-checks every cycle.
            always_comb begin
                w_nextState = r_state;
                if (flush) begin
                    w_nextState = IDLE;
                end else begin
                    case (r_state)
                        IDLE, HELD: if (w_issueAccepted)
                                        w_nextState = w_pending ? WAIT : HELD;
                        WAIT:       w_nextState = w_pending ? WAIT : HELD;
                        default:    w_nextState = IDLE;
                    endcase
                end
            end

            // Capture strobe: fires on the edge the lookup resolves.
            always_comb begin
                w_latch = 1'b0;
                if (!flush) begin
                    case (r_state)
                        IDLE, HELD: w_latch = w_issueAccepted && !w_pending;
                        WAIT:       w_latch = !w_pending;
                        default:    w_latch = 1'b0;
                    endcase
                end
            end

            // Operand hold register; flush leaves the last value in place.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)       r_data <= '0;
                else if (w_latch) r_data <= w_data;
            end

            assign w_portWait[p]                          = (w_nextState == WAIT);
            assign forwardedData[p*DATA_WIDTH +: DATA_WIDTH] = r_data;
        end
    endgenerate

    // Stall tracks next-state WAIT so data and stall release share an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_stall <= 1'b0;
        else        r_stall <= |w_portWait;
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_stallCycles <= '0;
        else if (counterClear)
            r_stallCycles <= '0;
        else if (r_stall && (r_stallCycles != '1))
            r_stallCycles <= r_stallCycles + 1'b1;
    end

    assign stall       = r_stall;
    assign stallCycles = r_stallCycles;

endmodule : forwarding_hazard_unit
`default_nettype wire
